// File: rtl/ir_pkg.sv
// Shared types and constants for the IR code player: sequencer states,
// the code terminator value and the delay-timer tick unit.
package ir_pkg;

  // One delay-timer tick, in microseconds
  localparam int unsigned TIMER_UNIT_US = 10;

  // An ON word of this value ends the code; an OFF word of this value skips the gap
  localparam int unsigned END_OF_CODE = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_ON  = 3'd1,
    LOAD_ON   = 3'd2,
    WAIT_ON   = 3'd3,
    FETCH_OFF = 3'd4,
    LOAD_OFF  = 3'd5,
    WAIT_OFF  = 3'd6,
    DONE      = 3'd7
  } seq_state_t;

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: half-period down-counter and phase flop. The phase flop
// doubles as the gated IR drive because it is cleared whenever not enabled.
module ir_carrier_gen #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 load_in,
  input  logic                 enable_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 phase_out
);

  logic [DIV_WIDTH-1:0] r_count;
  logic                 r_phase;

  // Load starts a burst high; outside a burst the phase is forced low
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (load_in) begin
      r_count <= div_in;
      r_phase <= 1'b1;
    end else if (enable_in) begin
      if (r_count == '0) begin
        r_count <= div_in;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count - DIV_WIDTH'(1);
      end
    end else begin
      r_phase <= 1'b0;
    end
  end

  assign phase_out = r_phase;

endmodule

// File: rtl/ir_code_sequencer.sv
// Plays one IR code from the code ROM: fetches alternating ON/OFF durations,
// loads each into the delay timer and gates the carrier onto ir_out during ON.
module ir_code_sequencer
  import ir_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [ADDR_WIDTH-1:0] code_addr_in,
  input  logic [DIV_WIDTH-1:0]  carrier_div_in,
  output logic                  rom_req_out,
  output logic [ADDR_WIDTH-1:0] rom_addr_out,
  input  logic [WIDTH-1:0]      rom_data_in,
  input  logic                  rom_valid_in,
  output logic [WIDTH-1:0]      delay_out,
  output logic                  update_delay_out,
  output logic                  timer_enable_out,
  output logic                  timer_reset_out,
  input  logic                  timer_busy_in,
  output logic                  ir_out,
  output logic                  busy_out,
  output logic                  done_out
);

  seq_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [WIDTH-1:0]      r_delay;
  logic                  r_rom_req;
  logic                  r_update;
  logic                  r_tmr_en;
  logic                  r_tmr_rst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wait_first;

  logic w_rom_hit;
  logic w_word_zero;
  logic w_wait_exit;
  logic w_carrier_load;
  logic w_carrier_en;
  logic w_phase;

  assign w_rom_hit   = r_rom_req & rom_valid_in;
  assign w_word_zero = (rom_data_in == WIDTH'(END_OF_CODE));
  // The timer raises busy one cycle after its load, so the first WAIT cycle never exits
  assign w_wait_exit = ~r_wait_first & ~timer_busy_in;

  assign w_carrier_load = ~abort_in & (r_state == FETCH_ON) & w_rom_hit & ~w_word_zero;
  assign w_carrier_en   = ~abort_in &
                          ((r_state == LOAD_ON) | ((r_state == WAIT_ON) & ~w_wait_exit));

  ir_carrier_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_carrier (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .load_in   (w_carrier_load),
    .enable_in (w_carrier_en),
    .div_in    (r_div),
    .phase_out (w_phase)
  );

  // Sequencer FSM; outputs are set on the transition into the state that shows them
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_div        <= '0;
      r_delay      <= '0;
      r_rom_req    <= 1'b0;
      r_update     <= 1'b0;
      r_tmr_en     <= 1'b0;
      r_tmr_rst    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_update  <= 1'b0;
      r_tmr_rst <= 1'b0;
      r_done    <= 1'b0;
      if (abort_in) begin
        r_state   <= IDLE;
        r_rom_req <= 1'b0;
        r_tmr_en  <= 1'b0;
        r_tmr_rst <= 1'b1;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_in) begin
              r_addr    <= code_addr_in;
              r_div     <= carrier_div_in;
              r_tmr_rst <= 1'b1;
              r_rom_req <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= FETCH_ON;
            end
          end
          FETCH_ON, FETCH_OFF: begin
            if (w_rom_hit) begin
              r_addr <= r_addr + ADDR_WIDTH'(1);
              if (!w_word_zero) begin
                r_delay   <= rom_data_in;
                r_update  <= 1'b1;
                r_rom_req <= 1'b0;
                r_state   <= (r_state == FETCH_ON) ? LOAD_ON : LOAD_OFF;
              end else if (r_state == FETCH_ON) begin
                r_rom_req <= 1'b0;
                r_state   <= DONE;
              end else begin
                // Empty OFF gap: request the next ON word straight away
                r_state <= FETCH_ON;
              end
            end
          end
          LOAD_ON, LOAD_OFF: begin
            r_tmr_en     <= 1'b1;
            r_wait_first <= 1'b1;
            r_state      <= (r_state == LOAD_ON) ? WAIT_ON : WAIT_OFF;
          end
          WAIT_ON, WAIT_OFF: begin
            if (r_wait_first) begin
              r_wait_first <= 1'b0;
            end else if (!timer_busy_in) begin
              r_tmr_en  <= 1'b0;
              r_rom_req <= 1'b1;
              r_state   <= (r_state == WAIT_ON) ? FETCH_OFF : FETCH_ON;
            end
          end
          DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rom_req_out      = r_rom_req;
  assign rom_addr_out     = r_addr;
  assign delay_out        = r_delay;
  assign update_delay_out = r_update;
  assign timer_enable_out = r_tmr_en;
  assign timer_reset_out  = r_tmr_rst;
  assign ir_out           = w_phase;
  assign busy_out         = r_busy;
  assign done_out         = r_done;

endmodule

// File: tb/tb_ir_code_sequencer.sv
// Bench for ir_code_sequencer: ROM and delay-timer models, a table of code
// playbacks with hand-computed results, plus abort and async-reset sequences.
module tb_ir_code_sequencer;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DIV_WIDTH  = 8;

  logic                  clock_in;
  logic                  reset_in;
  logic                  start_in;
  logic                  abort_in;
  logic [ADDR_WIDTH-1:0] code_addr_in;
  logic [DIV_WIDTH-1:0]  carrier_div_in;
  logic                  rom_req_out;
  logic [ADDR_WIDTH-1:0] rom_addr_out;
  logic [WIDTH-1:0]      rom_data_in;
  logic                  rom_valid_in;
  logic [WIDTH-1:0]      delay_out;
  logic                  update_delay_out;
  logic                  timer_enable_out;
  logic                  timer_reset_out;
  logic                  timer_busy_in;
  logic                  ir_out;
  logic                  busy_out;
  logic                  done_out;

  ir_code_sequencer #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .abort_in         (abort_in),
    .code_addr_in     (code_addr_in),
    .carrier_div_in   (carrier_div_in),
    .rom_req_out      (rom_req_out),
    .rom_addr_out     (rom_addr_out),
    .rom_data_in      (rom_data_in),
    .rom_valid_in     (rom_valid_in),
    .delay_out        (delay_out),
    .update_delay_out (update_delay_out),
    .timer_enable_out (timer_enable_out),
    .timer_reset_out  (timer_reset_out),
    .timer_busy_in    (timer_busy_in),
    .ir_out           (ir_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  typedef struct {
    int base;
    int div;
    int lat;
    int w[8];
    int nupd;
    int d0;
    int d1;
    int nreq;
    int high;
    int rises;
  } vec_t;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] rom_mem [0:1023];
  int  rom_lat;
  logic clr;

  // Model / monitor state, written only by the negedge process
  int cyc, n_upd, n_done, n_high, n_rise, n_req, n_unstable;
  int upd_vals[4];
  int req_addrs[8];
  int first_upd_cyc, first_valid_cyc, last_valid_cyc, done_cyc;
  int rom_cnt, tmr_cnt;
  logic [ADDR_WIDTH-1:0] rom_hold_addr;
  logic ir_prev, tmr_busy;

  assign timer_busy_in = tmr_busy;

  // ROM with fixed latency, delay timer (1 clock per unit) and output monitor
  always @(negedge clock_in) begin
    cyc = cyc + 1;
    if (clr) begin
      n_upd = 0; n_done = 0; n_high = 0; n_rise = 0; n_req = 0; n_unstable = 0;
      for (int i = 0; i < 4; i++) upd_vals[i] = 0;
      for (int i = 0; i < 8; i++) req_addrs[i] = -1;
      first_upd_cyc = 0; first_valid_cyc = 0; last_valid_cyc = 0; done_cyc = 0;
      rom_cnt = 0; rom_valid_in = 1'b0; rom_data_in = '0; rom_hold_addr = '0;
      tmr_cnt = 0; tmr_busy = 1'b0; ir_prev = 1'b0;
    end else begin
      if (update_delay_out) begin
        if (n_upd < 4) upd_vals[n_upd] = int'(delay_out);
        if (n_upd == 0) first_upd_cyc = cyc;
        n_upd = n_upd + 1;
      end
      if (done_out) begin
        n_done   = n_done + 1;
        done_cyc = cyc;
      end
      if (ir_out) n_high = n_high + 1;
      if (ir_out && !ir_prev) n_rise = n_rise + 1;
      ir_prev = ir_out;

      if (rom_valid_in) begin
        rom_valid_in = 1'b0;
        rom_cnt      = 0;
      end else if (rom_req_out) begin
        if (rom_cnt == 0) rom_hold_addr = rom_addr_out;
        else if (rom_addr_out != rom_hold_addr) n_unstable = n_unstable + 1;
        rom_cnt = rom_cnt + 1;
        if (rom_cnt >= rom_lat) begin
          rom_valid_in = 1'b1;
          rom_data_in  = rom_mem[rom_addr_out];
          if (n_req < 8) req_addrs[n_req] = int'(rom_addr_out);
          if (n_req == 0) first_valid_cyc = cyc;
          last_valid_cyc = cyc;
          n_req = n_req + 1;
        end
      end else begin
        rom_cnt = 0;
      end

      if (timer_reset_out) begin
        tmr_busy = 1'b0;
        tmr_cnt  = 0;
      end else if (update_delay_out) begin
        tmr_cnt  = int'(delay_out);
        tmr_busy = (delay_out != '0);
      end else if (timer_enable_out && tmr_busy) begin
        tmr_cnt = tmr_cnt - 1;
        if (tmr_cnt == 0) tmr_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_models();
    clr = 1'b1;
    @(negedge clock_in);
    #1 clr = 1'b0;
  endtask

  task automatic load_rom(input vec_t v);
    for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
    for (int i = 0; i < 8; i++) rom_mem[10'(v.base + i)] = 16'(v.w[i]);
    rom_lat = v.lat;
  endtask

  task automatic kick(input vec_t v);
    @(posedge clock_in); #1;
    code_addr_in   = ADDR_WIDTH'(v.base);
    carrier_div_in = DIV_WIDTH'(v.div);
    start_in       = 1'b1;
    @(posedge clock_in); #1;
    start_in = 1'b0;
  endtask

  task automatic run_case(input string tag, input vec_t v);
    clear_models();
    load_rom(v);
    kick(v);
    check({tag, " req after start"}, longint'(rom_req_out), 1);
    check({tag, " timer_reset after start"}, longint'(timer_reset_out), 1);
    check({tag, " busy after start"}, longint'(busy_out), 1);
    for (int c = 0; c < 3000 && n_done == 0; c++) @(posedge clock_in);
    repeat (6) @(posedge clock_in);
    #1;
    check({tag, " done count"}, n_done, 1);
    check({tag, " update count"}, n_upd, v.nupd);
    check({tag, " delay 0"}, upd_vals[0], v.d0);
    check({tag, " delay 1"}, upd_vals[1], v.d1);
    check({tag, " request count"}, n_req, v.nreq);
    for (int i = 0; i < v.nreq && i < 8; i++)
      check({tag, " request addr"}, req_addrs[i], (v.base + i) % 1024);
    check({tag, " addr unstable"}, n_unstable, 0);
    check({tag, " ir high cycles"}, n_high, v.high);
    check({tag, " ir rises"}, n_rise, v.rises);
    check({tag, " final addr"}, longint'(rom_addr_out), (v.base + v.nreq) % 1024);
    check({tag, " busy at end"}, longint'(busy_out), 0);
    check({tag, " req at end"}, longint'(rom_req_out), 0);
    check({tag, " done latency"}, done_cyc - last_valid_cyc, 2);
    if (v.nupd > 0) check({tag, " update latency"}, first_upd_cyc - first_valid_cyc, 1);
  endtask

  function automatic vec_t mk(input int base, div, lat, w0, w1, w2, w3, w4,
                              input int nupd, d0, d1, nreq, high, rises);
    vec_t v;
    v.base = base; v.div = div; v.lat = lat;
    v.w = '{w0, w1, w2, w3, w4, 0, 0, 0};
    v.nupd = nupd; v.d0 = d0; v.d1 = d1; v.nreq = nreq; v.high = high; v.rises = rises;
    return v;
  endfunction

  function automatic longint all_outs();
    return longint'({rom_req_out, rom_addr_out, delay_out, update_delay_out,
                     timer_enable_out, timer_reset_out, ir_out, busy_out, done_out});
  endfunction

  vec_t vecs[5];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    clr      = 1'b1;
    rom_lat  = 2;
    reset_in = 1'b1;
    start_in = 1'b0;
    abort_in = 1'b0;
    code_addr_in   = '0;
    carrier_div_in = '0;

    //            base   div lat words                 nupd d0  d1 nreq high rises
    vecs[0] = mk(10'h010, 3, 2,  5, 3, 0, 0, 0,        2,   5,  3, 3,   4,   1);
    vecs[1] = mk(10'h020, 0, 2,  4, 0, 2, 0, 0,        2,   4,  2, 5,   5,   5);
    vecs[2] = mk(10'h030, 1, 1, 12, 3, 0, 0, 0,        2,  12,  3, 3,   7,   4);
    vecs[3] = mk(10'h040, 2, 2,  0, 0, 0, 0, 0,        0,   0,  0, 1,   0,   0);
    vecs[4] = mk(10'h3FF, 1, 7,  6, 2, 0, 0, 0,        2,   6,  2, 3,   4,   2);

    repeat (3) @(posedge clock_in);
    #1;
    check("reset outputs", all_outs(), 0);
    reset_in = 1'b0;
    clear_models();

    for (int i = 0; i < 5; i++) run_case($sformatf("vec%0d", i), vecs[i]);

    // Abort mid WAIT_ON with a simultaneous start
    v = mk(10'h100, 2, 2, 100, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_models();
    load_rom(v);
    kick(v);
    for (int c = 0; c < 100 && !timer_enable_out; c++) @(posedge clock_in);
    repeat (10) @(posedge clock_in);
    #1;
    check("abort pre enable", longint'(timer_enable_out), 1);
    check("abort pre ir activity", longint'(n_high > 0), 1);
    abort_in     = 1'b1;
    start_in     = 1'b1;
    code_addr_in = 10'h000;
    @(posedge clock_in); #1;
    abort_in = 1'b0;
    start_in = 1'b0;
    check("abort ir", longint'(ir_out), 0);
    check("abort timer_reset", longint'(timer_reset_out), 1);
    check("abort busy", longint'(busy_out), 0);
    check("abort req", longint'(rom_req_out), 0);
    check("abort enable", longint'(timer_enable_out), 0);
    @(posedge clock_in); #1;
    check("abort timer_reset single", longint'(timer_reset_out), 0);
    repeat (20) @(posedge clock_in);
    #1;
    check("abort no done", n_done, 0);
    check("abort start ignored", longint'(busy_out), 0);
    check("abort no new request", n_req, 1);

    // Async reset while waiting on the OFF fetch, then replay
    v = mk(10'h200, 0, 7, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_models();
    load_rom(v);
    kick(v);
    for (int c = 0; c < 100 && n_upd == 0; c++) @(posedge clock_in);
    for (int c = 0; c < 100; c++) begin
      @(posedge clock_in); #1;
      if (rom_req_out) break;
    end
    check("reset pre req", longint'(rom_req_out), 1);
    #2 reset_in = 1'b1;
    #1;
    check("async reset outputs", all_outs(), 0);
    clear_models();
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    run_case("replay", mk(10'h200, 0, 2, 3, 5, 0, 0, 0, 2, 3, 5, 3, 2, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
